systolic_skew_feeder: RTL

//  Upstream feeder for the 8x8 one-bit (AND/OR) systolic matrix array.
//  - Accepts operand matrices A and B as a byte stream from the pin bus.
//  - Buffers both, then drives the array's top edge (column bus, in1) and left edge (row bus, in2).
//  - Drives diagonal skew so every A[i][k] meets its B[k][j] inside cell (i,j).
//  - Sequences flush and readout so the product C = A*B (boolean) drains from the array's bottom row.

---
 rtl/systolic_skew_feeder.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/systolic_skew_feeder.sv
`timescale 1ns/1ps
// systolic_skew_feeder
// Collects operand matrices A and B from a byte stream and feeds them into an
// NxN boolean (AND/OR) systolic array. A enters along the left edge and B along
// the top edge, each with a diagonal skew. The block then flushes the array and
// drains the product out of its bottom row.
// N must be a power of two: the low cnt bits double as the buffer row index.
module systolic_skew_feeder #(
    parameter int N     = 8,
    parameter int FLUSH = 2*N-2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] col_bus,
    output logic [N-1:0] row_bus,
    output logic         readout,
    output logic         busy,
    output logic         done
);
    // state     | meaning
    // ----------+-----------------------------------------------------------
    // S_LOAD    | accept 2N bytes: A rows 0..N-1, then B rows 0..N-1
    // S_STREAM  | drive skewed operands for t = 0..2N-2
    // S_FLUSH   | FLUSH idle cycles so the last operands reach cell (N-1,N-1)
    // S_READOUT | N cycles shifting accumulators out of the bottom row

    localparam int CW = $clog2(2*N);
    localparam int IW = $clog2(N);

    localparam logic [CW-1:0] LOAD_LAST   = CW'(2*N-1);
    localparam logic [CW-1:0] STREAM_LAST = CW'(2*N-2);
    localparam logic [CW-1:0] FLUSH_LAST  = CW'(FLUSH-1);
    localparam logic [CW-1:0] READ_LAST   = CW'(N-1);
    localparam logic [CW-1:0] B_FIRST     = CW'(N);

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_STREAM  = 2'd1,
        S_FLUSH   = 2'd2,
        S_READOUT = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   a_q [N];
    logic [N-1:0]   b_q [N];
    logic [N-1:0]   col_q, col_d;
    logic [N-1:0]   row_q, row_d;
    logic           readout_q, readout_d;
    logic           done_q, done_d;
    logic           load_we;

    // Next-state, counter and next values of the registered array-side outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        col_d     = '0;
        row_d     = '0;
        readout_d = 1'b0;
        done_d    = 1'b0;
        load_we   = 1'b0;
        case (state_q)
            S_LOAD: begin
                if (in_valid) begin
                    load_we = 1'b1;
                    if (cnt_q == LOAD_LAST) begin
                        cnt_d   = '0;
                        state_d = S_STREAM;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_STREAM: begin
                // Diagonal skew: lane j carries the operand with index t-j.
                for (int j = 0; j < N; j++) begin
                    for (int k = 0; k < N; k++) begin
                        if (int'(cnt_q) == j + k) begin
                            col_d[j] = col_d[j] | b_q[k][j];
                            row_d[j] = row_d[j] | a_q[j][k];
                        end
                    end
                end
                if (cnt_q == STREAM_LAST) begin
                    cnt_d   = '0;
                    state_d = S_FLUSH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FLUSH: begin
                if (cnt_q == FLUSH_LAST) begin
                    cnt_d   = '0;
                    state_d = S_READOUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_READOUT: begin
                // Buses stay zero so the array clears as its rows shift out.
                readout_d = 1'b1;
                if (cnt_q == READ_LAST) begin
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_LOAD;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_LOAD;
            cnt_q     <= '0;
            col_q     <= '0;
            row_q     <= '0;
            readout_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            col_q     <= col_d;
            row_q     <= row_d;
            readout_q <= readout_d;
            done_q    <= done_d;
        end
    end

    // Operand buffers: the first N bytes fill A, the next N fill B.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q <= '{default: '0};
            b_q <= '{default: '0};
        end else if (load_we) begin
            if (cnt_q < B_FIRST) begin
                a_q[cnt_q[IW-1:0]] <= in_data;
            end else begin
                b_q[cnt_q[IW-1:0]] <= in_data;
            end
        end
    end

    assign in_ready = (state_q == S_LOAD);
    assign busy     = (state_q != S_LOAD);
    assign col_bus  = col_q;
    assign row_bus  = row_q;
    assign readout  = readout_q;
    assign done     = done_q;

endmodule
